// File: rtl/adpll_tune_ctrl_pkg.sv
// adpll_pkg: shared state encoding and control-word constants for the ADPLL tuning sequencer
package adpll_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;
    localparam logic [4:0] CTRL_SAT   = 5'd31;
    localparam logic [4:0] THRESH_MIN = 5'd0;
    localparam logic [4:0] THRESH_MAX = 5'd31;
endpackage

// File: rtl/adpll_tune_ctrl_run_counter.sv
// run_counter: saturating run counter; hit flags the increment that reaches the limit
module run_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         hit
);
    logic [W-1:0] cnt;
    assign hit = inc && ({1'b0, cnt} + (W+1)'(1) >= {1'b0, limit});
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/adpll_tune_ctrl.sv
// adpll_tune_ctrl: DCO lock-acquisition sequencer (coarse threshold search, fine gain, lock/unlock)
module adpll_tune_ctrl
    import adpll_pkg::*;
#(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4,
    parameter int SETTLE     = 8,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       sample,
    input  logic       ctrl_sign,
    input  logic [4:0] ctrl,
    input  logic [4:0] lock_win,
    input  logic [4:0] kdco_coarse,
    input  logic [4:0] kdco_fine,
    input  logic [4:0] thresh_init,
    output logic [4:0] kdco,
    output logic [4:0] thresh_val,
    output logic       filt_clr,
    output logic       locked,
    output logic       tune_err,
    output logic [1:0] state
);
    state_t cur, nxt;
    logic [CNT_W-1:0] settle, settle_d;
    logic [4:0] thresh_d;
    logic smp, is_sat, is_in, is_out, go_idle;
    logic step_req, at_rail, step_ok;
    logic run_inc, run_clr, run_hit, unl_inc, unl_clr, unl_hit;
    logic filt_clr_d, tune_err_d;

    assign state    = cur;
    assign smp      = sample && enable;
    assign is_sat   = ctrl == CTRL_SAT;
    assign is_in    = !is_sat && ctrl <= lock_win;
    assign is_out   = !is_sat && !is_in;
    assign step_req = cur == ST_COARSE && smp && settle == '0 && is_sat;
    assign at_rail  = ctrl_sign ? thresh_val == THRESH_MAX : thresh_val == THRESH_MIN;
    assign step_ok  = step_req && !at_rail;
    // a sat sample breaks the coarse run whether or not the step could be taken
    assign run_inc  = smp && ((cur == ST_COARSE && settle == '0 && !is_sat) || (cur == ST_FINE && is_in));
    assign run_clr  = nxt != cur || step_req || (cur == ST_FINE && smp && is_out);
    assign unl_inc  = smp && cur == ST_LOCKED && is_out;
    assign unl_clr  = nxt != cur || (smp && is_in);

    run_counter #(.W(CNT_W)) u_run (
        .clk(clk), .reset(reset), .inc(run_inc), .clr(run_clr),
        .limit(CNT_W'(LOCK_CNT)), .hit(run_hit)
    );
    run_counter #(.W(CNT_W)) u_unlock (
        .clk(clk), .reset(reset), .inc(unl_inc), .clr(unl_clr),
        .limit(CNT_W'(UNLOCK_CNT)), .hit(unl_hit)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) cur <= ST_IDLE;
        else cur <= nxt;

    always_comb begin
        nxt = cur;
        if (!enable) nxt = ST_IDLE;
        else case (cur)
            ST_IDLE:   nxt = ST_COARSE;
            ST_COARSE: nxt = run_hit ? ST_FINE : ST_COARSE;
            ST_FINE:   nxt = (smp && is_sat) ? ST_COARSE : run_hit ? ST_LOCKED : ST_FINE;
            ST_LOCKED: nxt = (smp && is_sat) ? ST_COARSE : unl_hit ? ST_FINE : ST_LOCKED;
        endcase
    end

    always_comb begin
        go_idle    = !enable || cur == ST_IDLE;
        thresh_d   = go_idle ? thresh_init :
                     step_ok ? (ctrl_sign ? thresh_val + 5'd1 : thresh_val - 5'd1) : thresh_val;
        tune_err_d = !go_idle && (tune_err || (step_req && at_rail));
        // the integrator is cleared on every entry to or exit from COARSE and on each coarse step
        filt_clr_d = enable && (step_ok || (nxt != cur && (nxt == ST_COARSE || cur == ST_COARSE)));
        settle_d   = nxt != cur ? '0 :
                     step_ok ? CNT_W'(SETTLE) :
                     (cur == ST_COARSE && smp && settle != '0) ? settle - CNT_W'(1) : settle;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            kdco       <= '0;
            thresh_val <= '0;
            filt_clr   <= 1'b0;
            locked     <= 1'b0;
            tune_err   <= 1'b0;
            settle     <= '0;
        end else begin
            kdco       <= (nxt == ST_FINE || nxt == ST_LOCKED) ? kdco_fine : kdco_coarse;
            thresh_val <= thresh_d;
            filt_clr   <= filt_clr_d;
            locked     <= nxt == ST_LOCKED;
            tune_err   <= tune_err_d;
            settle     <= settle_d;
        end
endmodule

// File: tb/tb_adpll_tune_ctrl.sv
// tb_adpll_tune_ctrl: table, directed and randomized checks of adpll_tune_ctrl against a sample-level model
module tb_adpll_tune_ctrl;
    localparam int LOCK_CNT = 16, UNLOCK_CNT = 4, SETTLE = 8;

    logic clk = 0, reset = 1, enable = 0, sample = 0, ctrl_sign = 0;
    logic [4:0] ctrl = '0, lock_win = 5'd3, kdco_coarse = 5'd5, kdco_fine = 5'd9, thresh_init = '0;
    logic [4:0] kdco, thresh_val;
    logic filt_clr, locked, tune_err;
    logic [1:0] state;

    int n_tests = 0, n_fail = 0;
    int m_st = 0, m_th = 0, m_run = 0, m_unl = 0, m_set = 0, m_kdco = 0;
    bit m_fc = 0, m_err = 0, m_lk = 0;

    typedef struct {
        logic en, smp, sgn;
        logic [4:0] ctl;
        logic [1:0] st;
        logic [4:0] th;
        logic fc, err;
    } vec_t;
    vec_t tbl[10];

    adpll_tune_ctrl #(.LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .SETTLE(SETTLE), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sample(sample), .ctrl_sign(ctrl_sign),
        .ctrl(ctrl), .lock_win(lock_win), .kdco_coarse(kdco_coarse), .kdco_fine(kdco_fine),
        .thresh_init(thresh_init), .kdco(kdco), .thresh_val(thresh_val), .filt_clr(filt_clr),
        .locked(locked), .tune_err(tune_err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic go(int st);
        m_st = st; m_run = 0; m_unl = 0; m_set = 0;
    endtask

    // one clock of the sequencer, evaluated from the rules on the inputs present before the edge
    task automatic model_step();
        bit s, sat, inw;
        int t;
        s = sample && enable;
        sat = ctrl == 5'd31;
        inw = !sat && ctrl <= lock_win;
        m_fc = 0;
        if (reset) begin
            go(0); m_th = 0; m_err = 0; m_kdco = 0; m_lk = 0;
            return;
        end
        if (!enable) begin go(0); m_th = thresh_init; m_err = 0; end
        else if (m_st == 0) begin go(1); m_th = thresh_init; m_err = 0; m_fc = 1; end
        else if (s && m_st == 1) begin
            if (m_set > 0) m_set--;
            else if (sat) begin
                t = m_th + (ctrl_sign ? 1 : -1);
                m_run = 0;
                if (t < 0 || t > 31) m_err = 1;
                else begin m_th = t; m_set = SETTLE; m_fc = 1; end
            end else begin
                m_run++;
                if (m_run >= LOCK_CNT) begin go(2); m_fc = 1; end
            end
        end
        else if (s && sat) begin go(1); m_fc = 1; end
        else if (s && m_st == 2) begin
            if (!inw) m_run = 0;
            else begin m_run++; if (m_run >= LOCK_CNT) go(3); end
        end
        else if (s && m_st == 3) begin
            if (inw) m_unl = 0;
            else begin m_unl++; if (m_unl >= UNLOCK_CNT) go(2); end
        end
        m_kdco = m_st >= 2 ? int'(kdco_fine) : int'(kdco_coarse);
        m_lk = m_st == 3;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_o(string nm, int st, int th, bit fc, int kd, bit lk, bit er);
        chk({nm, ".state"}, 32'(state), st);
        chk({nm, ".thresh_val"}, 32'(thresh_val), th);
        chk({nm, ".filt_clr"}, 32'(filt_clr), 32'(fc));
        chk({nm, ".kdco"}, 32'(kdco), kd);
        chk({nm, ".locked"}, 32'(locked), 32'(lk));
        chk({nm, ".tune_err"}, 32'(tune_err), 32'(er));
    endtask

    task automatic check_model(string nm);
        expect_o(nm, m_st, m_th, m_fc, m_kdco, m_lk, m_err);
    endtask

    task automatic samp(logic [4:0] c, logic sg);
        ctrl = c; ctrl_sign = sg; sample = 1;
        tick();
        sample = 0;
    endtask

    initial begin
        int pat[8];
        int psat, pin, r;
        pat = '{10, 10, 10, 2, 10, 10, 10, 10};
        tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 5'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 5'd0,  2'd1, 5'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 5'd31, 2'd1, 5'd0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 5'd31, 2'd1, 5'd0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 5'd31, 2'd1, 5'd0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 5'd5,  2'd1, 5'd0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5'd31, 2'd0, 5'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 5'd0,  2'd0, 5'd0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 5'd0,  2'd1, 5'd0, 1'b1, 1'b0};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 5'd31, 2'd1, 5'd1, 1'b1, 1'b0};

        #3 expect_o("reset", 0, 0, 0, 0, 0, 0);
        tick();
        reset = 0;

        // rail behaviour at thresh_init = 0, then recovery through IDLE
        foreach (tbl[i]) begin
            enable = tbl[i].en; sample = tbl[i].smp; ctrl_sign = tbl[i].sgn; ctrl = tbl[i].ctl;
            tick();
            sample = 0;
            chk($sformatf("tbl%0d.state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d.thresh_val", i), 32'(thresh_val), 32'(tbl[i].th));
            chk($sformatf("tbl%0d.filt_clr", i), 32'(filt_clr), 32'(tbl[i].fc));
            chk($sformatf("tbl%0d.tune_err", i), 32'(tune_err), 32'(tbl[i].err));
        end

        // acquisition from thresh_init = 20
        thresh_init = 20; enable = 0;
        tick(); expect_o("idle", 0, 20, 0, 5, 0, 0);
        enable = 1;
        tick(); expect_o("enter", 1, 20, 1, 5, 0, 0);
        for (int k = 0; k < 3; k++) begin
            samp(31, 0); expect_o("step", 1, 19 - k, 1, 5, 0, 0);
            for (int j = 0; j < SETTLE; j++) begin
                samp(31, 0); expect_o("settle", 1, 19 - k, 0, 5, 0, 0);
            end
        end
        tick(); expect_o("nosample", 1, 17, 0, 5, 0, 0);
        for (int i = 0; i < LOCK_CNT; i++) begin
            samp(2, 0);
            expect_o("coarse2fine", i < LOCK_CNT - 1 ? 1 : 2, 17, i == LOCK_CNT - 1, i < LOCK_CNT - 1 ? 5 : 9, 0, 0);
        end
        for (int i = 0; i < LOCK_CNT; i++) begin
            samp(2, 0);
            expect_o("fine2lock", i < LOCK_CNT - 1 ? 2 : 3, 17, 0, 9, i == LOCK_CNT - 1, 0);
        end

        // unlock needs UNLOCK_CNT consecutive out samples
        for (int i = 0; i < 8; i++) begin
            samp(5'(pat[i]), 0);
            expect_o("unlock", i < 7 ? 3 : 2, 17, 0, 9, i < 7, 0);
        end
        for (int i = 0; i < LOCK_CNT; i++) samp(2, 1);
        expect_o("relock", 3, 17, 0, 9, 1, 0);
        samp(31, 0); expect_o("sat_locked", 1, 17, 1, 5, 0, 0);
        tick(); expect_o("sat_locked_pulse", 1, 17, 0, 5, 0, 0);

        // enable low beats a coincident sat sample in FINE
        for (int i = 0; i < LOCK_CNT; i++) samp(2, 0);
        expect_o("refine", 2, 17, 1, 9, 0, 0);
        enable = 0;
        samp(31, 0); expect_o("override", 0, 20, 0, 5, 0, 0);

        // asynchronous reset mid-COARSE
        enable = 1;
        tick(); expect_o("reenter", 1, 20, 1, 5, 0, 0);
        samp(31, 0); expect_o("prereset", 1, 19, 1, 5, 0, 0);
        #2 reset = 1;
        #1 expect_o("async_reset", 0, 0, 0, 0, 0, 0);
        tick(); expect_o("held_reset", 0, 0, 0, 0, 0, 0);
        reset = 0;
        tick(); expect_o("post_reset", 1, 20, 1, 5, 0, 0);

        // randomized traffic against the model
        for (int b = 0; b < 12; b++) begin
            psat = b % 3 == 0 ? 30 : b % 3 == 1 ? 2 : 0;
            pin = b % 2 == 0 ? 95 : 60;
            lock_win = 5'($urandom_range(0, 8));
            kdco_coarse = 5'($urandom_range(0, 31));
            kdco_fine = 5'($urandom_range(0, 31));
            r = $urandom_range(0, 4);
            thresh_init = r == 0 ? 5'd0 : r == 1 ? 5'd31 : r == 2 ? 5'd1 : r == 3 ? 5'd30 : 5'($urandom_range(0, 31));
            for (int c = 0; c < 250; c++) begin
                enable = $urandom_range(0, 199) != 0;
                sample = $urandom_range(0, 9) < 7;
                r = $urandom_range(0, 99);
                ctrl = r < psat ? 5'd31 : r < psat + pin ? 5'($urandom_range(0, lock_win)) :
                       5'($urandom_range(lock_win + 1, 30));
                ctrl_sign = 1'($urandom_range(0, 1));
                tick();
                check_model("rand");
            end
        end
        sample = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
